csr_sched: RTL and testbench

- Issue controller between rename and the CSR execution unit.
- Buffers CSR instructions from rename in a small FIFO and holds each one until it is the oldest instruction in the ROB (robid equals the ROB head).
- Issues exactly one CSR operation at a time, then waits for the CSR unit's writeback before issuing the next.
- Serialises all CSR side effects, makes them non-speculative, and clears cleanly on ROB flush.

---
 rtl/csr_pkg.sv | 44 ++++
 rtl/csr_sched_if.sv | 49 ++++
 rtl/csr_sched_fifo.sv | 67 ++++++
 rtl/csr_sched.sv | 138 +++++++++++++
 tb/tb_csr_sched.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// ---------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the CSR issue scheduler:
//   - sched_state_t : scheduler FSM states
//   - csr_funct_t   : funct field encodings carried in op[1:0]
//   - csr_entry_t   : one buffered CSR instruction (82 bits)
//   - counter CSR address constants and a small address helper
// ---------------------------------------------------------------------------
package csr_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_HEAD = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_WB   = 3'd3,
    S_DRAIN     = 3'd4
  } sched_state_t;

  typedef enum logic [1:0] {
    FUNCT_RW = 2'b01,
    FUNCT_RS = 2'b10,
    FUNCT_RC = 2'b11
  } csr_funct_t;

  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef struct packed {
    logic [4:0]  op;
    logic [6:0]  robid;
    logic [5:0]  rd;
    logic [31:0] op1;
    logic [31:0] imm;
  } csr_entry_t;

  // True for the machine counter CSRs this core implements.
  function automatic logic is_counter_csr(input logic [11:0] addr);
    return (addr == CSR_MCYCLE)  || (addr == CSR_MINSTRET) ||
           (addr == CSR_MCYCLEH) || (addr == CSR_MINSTRETH);
  endfunction

endpackage

// File: rtl/csr_sched_if.sv
// ---------------------------------------------------------------------------
// csr_sched_if
// Bundles the rename push, ROB control, CSR-unit issue and writeback signals
// of the CSR scheduler.
//   master : the surrounding pipeline (rename, ROB, CSR unit)
//   slave  : the scheduler itself
// ---------------------------------------------------------------------------
interface csr_sched_if;

  // rename -> scheduler
  logic        rename_csr_write;
  logic [4:0]  rename_op;
  logic [6:0]  rename_robid;
  logic [5:0]  rename_rd;
  logic [31:0] rename_op1;
  logic [31:0] rename_imm;
  logic        sched_stall;

  // ROB -> scheduler
  logic        rob_flush;
  logic [6:0]  rob_csr_head;

  // scheduler -> CSR unit
  logic        sched_write;
  logic [4:0]  sched_op;
  logic [6:0]  sched_robid;
  logic [5:0]  sched_rd;
  logic [31:0] sched_op1;
  logic [31:0] sched_imm;

  // CSR unit -> scheduler
  logic        csr_valid;
  logic        sched_busy;

  modport master (
    output rename_csr_write, rename_op, rename_robid, rename_rd,
           rename_op1, rename_imm, rob_flush, rob_csr_head, csr_valid,
    input  sched_stall, sched_write, sched_op, sched_robid, sched_rd,
           sched_op1, sched_imm, sched_busy
  );

  modport slave (
    input  rename_csr_write, rename_op, rename_robid, rename_rd,
           rename_op1, rename_imm, rob_flush, rob_csr_head, csr_valid,
    output sched_stall, sched_write, sched_op, sched_robid, sched_rd,
           sched_op1, sched_imm, sched_busy
  );

endinterface

// File: rtl/csr_sched_fifo.sv
// ---------------------------------------------------------------------------
// csr_sched_fifo
// Synchronous FIFO of csr_entry_t with a synchronous clear.
//   clk, rst : clock, asynchronous active-low reset
//   push/din : write din at the tail (caller guarantees ~full)
//   pop      : drop the head entry (caller guarantees ~empty)
//   clear    : empty the FIFO; overrides push and pop
//   full, empty, count, head : registered occupancy and head entry
// ---------------------------------------------------------------------------
module csr_sched_fifo
  import csr_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTRW  = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic           clear,
  input  csr_entry_t     din,
  output logic           full,
  output logic           empty,
  output logic [PTRW:0]  count,
  output csr_entry_t     head
);

  localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(1);
  localparam logic [PTRW:0]   CNT_ONE  = (PTRW + 1)'(1);
  localparam logic [PTRW:0]   CNT_FULL = (PTRW + 1)'(DEPTH);

  csr_entry_t          mem [DEPTH];
  logic [PTRW-1:0]     wr_ptr;
  logic [PTRW-1:0]     rd_ptr;

  // NOTE: the storage array has no reset; only pointers and count do, and
  // a slot is never read as valid before it has been written.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are exactly PTRW bits, so they wrap modulo DEPTH.
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/csr_sched.sv
// ---------------------------------------------------------------------------
// csr_sched
// Issue controller between rename and the CSR execution unit. CSR
// instructions are buffered in order and each is issued only when it is the
// oldest instruction in the ROB; one operation is in flight at a time and
// the next issue waits for the CSR unit's writeback. A ROB flush empties the
// buffer; an already-issued operation is drained before new work is taken.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : csr_sched_if.slave (rename push, ROB head/flush, issue,
//              writeback, stall and busy)
// ---------------------------------------------------------------------------
module csr_sched
  import csr_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTRW  = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  csr_sched_if.slave  bus
);

  localparam logic [PTRW:0] CNT_ONE = (PTRW + 1)'(1);

  sched_state_t   state;
  sched_state_t   state_nxt;

  logic           full;
  logic           empty;
  logic [PTRW:0]  count;
  csr_entry_t     head;
  csr_entry_t     rename_entry;
  csr_entry_t     issued_q;

  logic           push;
  logic           pop;
  logic           head_match;
  logic           entry_remains;
  logic           write;
  logic           stall;
  logic           busy;

  assign rename_entry = '{op:    bus.rename_op,
                          robid: bus.rename_robid,
                          rd:    bus.rename_rd,
                          op1:   bus.rename_op1,
                          imm:   bus.rename_imm};

  // Flush outranks both FIFO operations in the same cycle.
  assign push = bus.rename_csr_write && !stall && !bus.rob_flush;
  assign pop  = (state == S_WAIT_WB) && bus.csr_valid && !bus.rob_flush;

  // Exact robid equality against the registered FIFO head.
  assign head_match = (head.robid == bus.rob_csr_head);

  // On a pop, something is left if more than one entry was held or a new
  // one arrives in the same cycle.
  assign entry_remains = (count != CNT_ONE) || push;

  csr_sched_fifo #(.DEPTH(DEPTH), .PTRW(PTRW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (bus.rob_flush),
    .din   (rename_entry),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!bus.rob_flush && !empty) state_nxt = S_WAIT_HEAD;
      end
      S_WAIT_HEAD: begin
        if (bus.rob_flush)   state_nxt = S_IDLE;
        else if (head_match) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        // The CSR unit samples the pulse regardless, so a flush here must
        // still wait for its writeback.
        state_nxt = bus.rob_flush ? S_DRAIN : S_WAIT_WB;
      end
      S_WAIT_WB: begin
        if (bus.rob_flush)      state_nxt = bus.csr_valid ? S_IDLE : S_DRAIN;
        else if (bus.csr_valid) state_nxt = entry_remains ? S_WAIT_HEAD : S_IDLE;
      end
      S_DRAIN: begin
        if (bus.csr_valid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    write = 1'b0;
    busy  = 1'b1;
    stall = full;
    case (state)
      S_IDLE:  busy  = 1'b0;
      S_ISSUE: write = 1'b1;
      S_DRAIN: stall = 1'b1;
      default: ;
    endcase
  end

  // Payload is captured on entry to ISSUE and held until the next issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issued_q <= '0;
    end else if ((state == S_WAIT_HEAD) && (state_nxt == S_ISSUE)) begin
      issued_q <= head;
    end
  end

  assign bus.sched_write = write;
  assign bus.sched_stall = stall;
  assign bus.sched_busy  = busy;
  assign bus.sched_op    = issued_q.op;
  assign bus.sched_robid = issued_q.robid;
  assign bus.sched_rd    = issued_q.rd;
  assign bus.sched_op1   = issued_q.op1;
  assign bus.sched_imm   = issued_q.imm;

endmodule

// File: tb/tb_csr_sched.sv
// ---------------------------------------------------------------------------
// tb_csr_sched
// Self-checking bench for csr_sched (DEPTH=2). The reference model is a
// queue of accepted-but-not-retired instructions plus two flags (an issued
// op awaiting writeback, and a post-flush drain). Stimulus pushes accepted
// instructions into the queue; an independent monitor compares every issue
// pulse against the queue head and checks the stall output every cycle.
// ---------------------------------------------------------------------------
module tb_csr_sched;
  import csr_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  csr_sched_if bus ();

  csr_sched #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model
  csr_entry_t mq[$];
  bit         outstanding = 1'b0;
  bit         draining    = 1'b0;

  int         cyc = 0;
  int         issues = 0;
  int         last_issue_cyc = -100;
  logic [6:0] head_prev = '0;

  // Output snapshot of the most recent step() cycle
  logic       s_write;
  logic       s_stall;
  logic       s_busy;
  logic [6:0] s_robid;

  logic [11:0] addrs [4];

  task automatic check(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_stall();
    return (mq.size() == DEPTH) || draining;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: stall every cycle, and every issue against the oldest accepted
  // instruction and the ROB head seen in the preceding cycle.
  always @(negedge clk) begin
    csr_entry_t got;
    if (rst) begin
      check("stall", bus.sched_stall, model_stall());
      if (bus.csr_valid)
        check("csr_valid_legal",
              (dut.state == S_WAIT_WB) || (dut.state == S_DRAIN), 1'b1);
      if (bus.sched_write) begin
        issues++;
        got = '{op: bus.sched_op, robid: bus.sched_robid, rd: bus.sched_rd,
                op1: bus.sched_op1, imm: bus.sched_imm};
        if (mq.size() == 0) begin
          check("unexpected_issue", bus.sched_write, 1'b0);
        end else begin
          check("issue_payload", got, mq[0]);
        end
        check("issue_head", bus.sched_robid, head_prev);
        check("issue_spacing", (cyc - last_issue_cyc) >= 3, 1'b1);
        last_issue_cyc = cyc;
      end
      head_prev = bus.rob_csr_head;
    end
  end

  task automatic idle_inputs();
    bus.rename_csr_write = 1'b0;
    bus.rename_op        = '0;
    bus.rename_robid     = '0;
    bus.rename_rd        = '0;
    bus.rename_op1       = '0;
    bus.rename_imm       = '0;
    bus.rob_flush        = 1'b0;
    bus.rob_csr_head     = '0;
    bus.csr_valid        = 1'b0;
  endtask

  task automatic load(input logic [6:0] robid, input csr_funct_t f,
                      input logic [11:0] addr);
    bus.rename_csr_write = 1'b1;
    bus.rename_op        = {3'($urandom), f};
    bus.rename_robid     = robid;
    bus.rename_rd        = 6'($urandom);
    bus.rename_op1       = $urandom;
    bus.rename_imm       = {20'($urandom), addr};
  endtask

  // One clock with the inputs currently driven; updates the model after
  // the edge from the rules for push, writeback and flush.
  task automatic step();
    bit         acc;
    bit         fl;
    bit         cv;
    csr_entry_t e;
    @(negedge clk);
    acc = bus.rename_csr_write && !model_stall() && !bus.rob_flush;
    fl  = bus.rob_flush;
    cv  = bus.csr_valid;
    e   = '{op: bus.rename_op, robid: bus.rename_robid, rd: bus.rename_rd,
            op1: bus.rename_op1, imm: bus.rename_imm};
    s_write = bus.sched_write;
    s_stall = bus.sched_stall;
    s_busy  = bus.sched_busy;
    s_robid = bus.sched_robid;
    if (bus.sched_write) outstanding = 1'b1;
    @(posedge clk);
    #1;
    if (fl) begin
      mq.delete();
      if (draining || outstanding) draining = !cv;
      outstanding = 1'b0;
    end else begin
      if (draining && cv) begin
        draining = 1'b0;
      end else if (outstanding && cv) begin
        void'(mq.pop_front());
        outstanding = 1'b0;
      end
      if (acc) mq.push_back(e);
    end
  endtask

  task automatic wait_issue(input int max_cycles, input string name,
                            output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (!s_write && (k < max_cycles));
    check(name, s_write, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;
    logic [6:0] next_id;

    addrs = '{CSR_MCYCLE, CSR_MINSTRET, CSR_MCYCLEH, CSR_MINSTRETH};
    idle_inputs();

    // ---- reset values ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_write", bus.sched_write, 1'b0);
    check("rst_stall", bus.sched_stall, 1'b0);
    check("rst_busy",  bus.sched_busy,  1'b0);
    check("rst_payload", {bus.sched_op, bus.sched_robid, bus.sched_rd,
                          bus.sched_op1, bus.sched_imm}, '0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // ---- single op ----
    bus.rob_csr_head = 7'd3;
    load(7'd5, FUNCT_RW, CSR_MCYCLE);
    step();
    bus.rename_csr_write = 1'b0;
    n = issues;
    repeat (4) step();
    check("t1_no_issue_head_mismatch", issues, n);
    bus.rob_csr_head = 7'd5;
    step();
    check("t1_no_write_in_match_cycle", s_write, 1'b0);
    step();
    check("t1_issue_write", s_write, 1'b1);
    check("t1_issue_robid", s_robid, 7'd5);
    bus.csr_valid = 1'b1;
    step();
    bus.csr_valid = 1'b0;
    check("t1_idle_after_wb", dut.state, S_IDLE);
    step();
    check("t1_busy_low", s_busy, 1'b0);
    check("t1_payload_hold", s_robid, 7'd5);

    // ---- back-to-back ----
    bus.rob_csr_head = 7'd10;
    load(7'd10, FUNCT_RS, CSR_MINSTRET);
    step();
    load(7'd11, FUNCT_RC, CSR_MCYCLEH);
    step();
    bus.rename_csr_write = 1'b0;
    n = issues;
    wait_issue(20, "t2_first_issue", k);
    check("t2_first_robid", s_robid, 7'd10);
    bus.csr_valid = 1'b1;
    step();
    bus.csr_valid = 1'b0;
    bus.rob_csr_head = 7'd11;
    wait_issue(20, "t2_second_issue", k);
    check("t2_issue_gap", k + 1, 3);
    check("t2_second_robid", s_robid, 7'd11);
    bus.csr_valid = 1'b1;
    step();
    bus.csr_valid = 1'b0;
    repeat (4) step();
    check("t2_two_issues", issues - n, 2);

    // ---- full ----
    bus.rob_csr_head = 7'd0;
    load(7'd20, FUNCT_RW, CSR_MINSTRETH);
    step();
    load(7'd21, FUNCT_RS, CSR_MCYCLE);
    step();
    check("t3_stall_before_full", s_stall, 1'b0);
    load(7'd22, FUNCT_RC, CSR_MINSTRET);
    step();
    check("t3_stall_full", s_stall, 1'b1);
    bus.rename_csr_write = 1'b0;
    check("t3_third_dropped", dut.u_fifo.count, 2);
    bus.rob_csr_head = 7'd20;
    wait_issue(20, "t3_issue", k);
    check("t3_issue_robid", s_robid, 7'd20);
    bus.csr_valid = 1'b1;
    step();
    bus.csr_valid = 1'b0;
    step();
    check("t3_stall_clear_after_pop", s_stall, 1'b0);

    // ---- push while full during writeback ----
    load(7'd23, FUNCT_RW, CSR_MCYCLEH);
    step();
    bus.rename_csr_write = 1'b0;
    check("t4_refilled", dut.u_fifo.count, 2);
    bus.rob_csr_head = 7'd21;
    wait_issue(20, "t4_issue", k);
    check("t4_issue_robid", s_robid, 7'd21);
    bus.csr_valid = 1'b1;
    load(7'd24, FUNCT_RS, CSR_MCYCLE);
    step();
    check("t4_stall_on_wb", s_stall, 1'b1);
    bus.csr_valid = 1'b0;
    bus.rename_csr_write = 1'b0;
    check("t4_push_dropped", dut.u_fifo.count, 1);

    // ---- push and pop together with one entry ----
    bus.rob_csr_head = 7'd23;
    wait_issue(20, "t4b_issue", k);
    check("t4b_issue_robid", s_robid, 7'd23);
    bus.csr_valid = 1'b1;
    load(7'd25, FUNCT_RC, CSR_MINSTRETH);
    step();
    bus.csr_valid = 1'b0;
    bus.rename_csr_write = 1'b0;
    check("t4b_count_kept", dut.u_fifo.count, 1);
    check("t4b_wait_head", dut.state, S_WAIT_HEAD);
    bus.rob_csr_head = 7'd25;
    wait_issue(20, "t4b_next_issue", k);
    check("t4b_next_robid", s_robid, 7'd25);
    bus.csr_valid = 1'b1;
    step();
    bus.csr_valid = 1'b0;
    check("t4b_idle", dut.state, S_IDLE);

    // ---- flush in WAIT_WB ----
    bus.rob_csr_head = 7'd7;
    load(7'd7, FUNCT_RW, CSR_MCYCLE);
    step();
    load(7'd8, FUNCT_RS, CSR_MINSTRET);
    step();
    bus.rename_csr_write = 1'b0;
    wait_issue(20, "t5_issue", k);
    check("t5_issue_robid", s_robid, 7'd7);
    bus.rob_flush = 1'b1;
    step();
    bus.rob_flush = 1'b0;
    check("t5_drain", dut.state, S_DRAIN);
    step();
    check("t5_stall_in_drain", s_stall, 1'b1);
    check("t5_fifo_empty", dut.u_fifo.empty, 1'b1);
    bus.csr_valid = 1'b1;
    step();
    bus.csr_valid = 1'b0;
    check("t5_idle_after_drain", dut.state, S_IDLE);
    n = issues;
    bus.rob_csr_head = 7'd8;
    repeat (5) step();
    check("t5_no_issue_after_flush", issues, n);
    check("t5_busy_low", s_busy, 1'b0);

    // ---- asynchronous reset during ISSUE ----
    bus.rob_csr_head = 7'd40;
    load(7'd40, FUNCT_RW, CSR_MCYCLEH);
    step();
    bus.rename_csr_write = 1'b0;
    k = 0;
    while ((dut.state != S_ISSUE) && (k < 20)) begin
      step();
      k++;
    end
    check("t6_reached_issue", dut.state, S_ISSUE);
    check("t6_write_before_rst", bus.sched_write, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("t6_write_async_low", bus.sched_write, 1'b0);
    check("t6_state_idle", dut.state, S_IDLE);
    check("t6_fifo_empty", dut.u_fifo.empty, 1'b1);
    check("t6_payload_cleared", bus.sched_robid, 7'd0);
    mq.delete();
    outstanding    = 1'b0;
    draining       = 1'b0;
    last_issue_cyc = -100;
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // ---- randomized traffic ----
    next_id = 7'd64;
    n = issues;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        load(next_id, csr_funct_t'($urandom_range(1, 3)),
             addrs[$urandom_range(0, 3)]);
        next_id = next_id + 7'd1;
      end else begin
        bus.rename_csr_write = 1'b0;
      end
      if ((mq.size() != 0) && ($urandom_range(0, 3) != 0))
        bus.rob_csr_head = mq[0].robid;
      else
        bus.rob_csr_head = 7'($urandom);
      bus.csr_valid = (outstanding || draining) && ($urandom_range(0, 2) == 0);
      bus.rob_flush = ($urandom_range(0, 39) == 0);
      step();
    end
    bus.rob_flush        = 1'b0;
    bus.rename_csr_write = 1'b0;
    k = 0;
    while (((mq.size() != 0) || outstanding || draining) && (k < 300)) begin
      if (mq.size() != 0) bus.rob_csr_head = mq[0].robid;
      bus.csr_valid = outstanding || draining;
      step();
      k++;
    end
    bus.csr_valid = 1'b0;
    repeat (3) step();
    check("rand_drained_idle", dut.state, S_IDLE);
    check("rand_busy_low", s_busy, 1'b0);
    check("rand_activity", issues > n, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
